line_mem_ctrl: RTL and testbench
================================

Name: line_mem_ctrl

Overview:
Backing-memory responder for the L1 cache refill/writeback interface. It services two request types: 128-bit line fills (cache load) and 128-bit line writebacks (dirty eviction). Internal storage is a word-wide array accessed one 32-bit beat per cycle after a configurable access latency. It sits between the cache set controller and main memory, and is the memory-side end of the cache's line load/writeback path.

Parameters:
- MEM_WORDS, 4096, depth of the internal 32-bit word array; must be a power of 2 and ≥4.
- LATENCY, 4, idle cycles between request acceptance and the first beat; 0 is legal.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_write  in  1  1 = writeback, 0 = fill.
- req_addr  in  32  line address; bits [3:0] are ignored.
- req_wbdata  in  128  writeback line; word w occupies bits [32w+31:32w].
- resp_valid  out  1  one-cycle completion pulse for fill or writeback.
- resp_ldata  out  128  line data; same word packing as req_wbdata.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE; req_ready=1; resp_valid=0; resp_ldata=0; busy=0; counters=0.
  - Memory array contents are not cleared.
- Handshake:
  - A request is accepted at a rising edge with req_valid && req_ready.
  - At acceptance, latch base word index = req_addr[ ... :4]·4 mod MEM_WORDS, plus req_write and req_wbdata.
  - Inputs may change freely after acceptance.
  - req_ready=1 only in IDLE. req_valid outside IDLE is ignored; no queueing.
- States:
  - IDLE: wait for acceptance. Go to WAIT if LATENCY>0, else go to BEAT.
  - WAIT: count LATENCY cycles, then go to BEAT.
  - BEAT: 4 cycles with beat counter b=0..3. Word index = base+b; the base is 4-aligned, so no intra-line wrap.
    - Write: mem[idx] <= wbdata word b.
    - Fill: line_buf word b <= mem[idx], registered synchronous read.
    - After b=3, go to DONE.
  - DONE: resp_valid=1 for exactly one cycle, then go to IDLE.
    - Fill: resp_ldata = assembled line.
    - Writeback: resp_ldata = the written line (echo).
    - resp_ldata holds its value until the next DONE.
- Timing: if acceptance is at edge E0, resp_valid is high during the cycle after edge E0+LATENCY+4. req_ready returns high after edge E0+LATENCY+5. Back-to-back throughput is one line per LATENCY+6 cycles including the IDLE accept cycle.
- Address boundaries:
  - Addresses beyond MEM_WORDS·4 bytes alias modulo the array size.
  - Misaligned req_addr is treated as its aligned line.
- Simultaneous events:
  - A fill immediately following a writeback to the same line returns the newly written data.
  - rst=0 overrides all activity.
- Reset mid-operation: abort immediately and return to IDLE with no resp_valid. Writeback beats already committed stay in memory; uncommitted beats are not written.

Optional Feature:
- Macro: LINE_MEM_STATS_EN.
- Defined:
  - Adds output ports fill_cnt [31:0] and wb_cnt [31:0], placed after busy.
  - Each counter increments by 1 on the cycle its DONE pulse fires.
  - Both reset to 0 and wrap modulo 2^32.
  - An aborted operation does not count.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Writeback then fill, LATENCY=4: writeback addr 0x0000_0040, data {0x44444444,0x33333333,0x22222222,0x11111111}. Then fill addr 0x0000_004C (misaligned) -> fill returns the identical 128-bit line. resp_valid pulses exactly 8 edges after each acceptance.
- LATENCY=0: fill accepted at edge E0 -> resp_valid high only in the cycle after edge E0+4. req_ready low from E0+1 through E0+4, high again after E0+5.
- Busy back-pressure: assert req_valid (fill, addr 0x100) continuously while a writeback is in flight. The second request is accepted only at the first edge with req_ready=1, and exactly one resp_valid is seen per request.
- Reset mid-writeback: write line 0xAAAA_AAAA×4 to addr 0x200, then write 0x5555_5555×4 to the same addr. Drop rst for one cycle after beat 1 of the second writeback. Then fill addr 0x200 -> words 0-1 read 0x5555_5555, words 2-3 read 0xAAAA_AAAA, and there is no resp_valid for the aborted request.
- Aliasing, MEM_WORDS=4096: writeback to addr 0x0001_0010, then fill addr 0x0000_0010 -> returns the same line.
- With LINE_MEM_STATS_EN: 3 fills and 2 writebacks, one of them reset-aborted -> counts reflect only completed operations after the reset. Counts read 0 immediately after reset.

Source files
------------

// File: rtl/line_mem_ctrl.sv
// Memory-side responder for L1 line fills and writebacks: 128-bit lines moved as four
// 32-bit beats after a LATENCY-cycle wait. Define LINE_MEM_STATS_EN to add fill_cnt/wb_cnt.
module line_mem_ctrl #(
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned LATENCY   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [31:0]  req_addr,
  input  logic [127:0] req_wbdata,
  output logic         resp_valid,
  output logic [127:0] resp_ldata,
  output logic         busy
`ifdef LINE_MEM_STATS_EN
  ,
  output logic [31:0]  fill_cnt,
  output logic [31:0]  wb_cnt
`endif
);

  localparam int unsigned IW = $clog2(MEM_WORDS);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'((LATENCY > 0) ? LATENCY - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, BEAT, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [1:0]     beat_q, beat_d;
  logic [IW-1:0]  base_q, base_d;
  logic           write_q, write_d;
  logic [127:0]   data_q, data_d;
  logic [127:0]   resp_ldata_q, resp_ldata_d;

  logic [31:0]    mem [MEM_WORDS];
  logic [IW-1:0]  mem_idx;
  logic [31:0]    mem_rdata;
  logic [31:0]    mem_wdata;
  logic           mem_we;
  logic           addr_unused;

`ifdef LINE_MEM_STATS_EN
  logic [31:0]    fill_cnt_q, fill_cnt_d;
  logic [31:0]    wb_cnt_q, wb_cnt_d;
`endif

  // Lines are 4-aligned in the word array, so OR-ing in the beat never carries.
  assign mem_idx     = base_q | IW'(beat_q);
  assign mem_rdata   = mem[mem_idx];
  assign mem_wdata   = data_q[32*beat_q +: 32];
  assign addr_unused = ^{req_addr[31:IW+2], req_addr[1:0]};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    beat_d       = beat_q;
    base_d       = base_q;
    write_d      = write_q;
    data_d       = data_q;
    resp_ldata_d = resp_ldata_q;
    mem_we       = 1'b0;
`ifdef LINE_MEM_STATS_EN
    fill_cnt_d   = fill_cnt_q;
    wb_cnt_d     = wb_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          base_d     = req_addr[IW+1:2] & ~IW'(3);
          write_d    = req_write;
          data_d     = req_wbdata;
          beat_d     = 2'd0;
          wait_cnt_d = '0;
          state_d    = (LATENCY > 0) ? WAIT : BEAT;
        end
      end
      WAIT: begin
        if (wait_cnt_q == WAIT_LAST) state_d = BEAT;
        else                         wait_cnt_d = wait_cnt_q + CW'(1);
      end
      BEAT: begin
        if (write_q) mem_we = 1'b1;
        else         data_d[32*beat_q +: 32] = mem_rdata;
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) begin
          state_d      = DONE;
          // The last fill word is still arriving from the array, so splice it in directly.
          resp_ldata_d = write_q ? data_q : {mem_rdata, data_q[95:0]};
`ifdef LINE_MEM_STATS_EN
          if (write_q) wb_cnt_d   = wb_cnt_q + 32'd1;
          else         fill_cnt_d = fill_cnt_q + 32'd1;
`endif
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      beat_q       <= 2'd0;
      base_q       <= '0;
      write_q      <= 1'b0;
      data_q       <= '0;
      resp_ldata_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      beat_q       <= beat_d;
      base_q       <= base_d;
      write_q      <= write_d;
      data_q       <= data_d;
      resp_ldata_q <= resp_ldata_d;
    end
  end

  // NOTE: the array has no reset; a reset only suppresses the write on its own edge.
  always_ff @(posedge clk) begin
    if (rst && mem_we) mem[mem_idx] <= mem_wdata;
  end

`ifdef LINE_MEM_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      fill_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      fill_cnt_q <= fill_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  assign fill_cnt = fill_cnt_q;
  assign wb_cnt   = wb_cnt_q;
`endif

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign resp_valid = (state_q == DONE);
  assign resp_ldata = resp_ldata_q;

endmodule

// File: tb/tb_line_mem_ctrl.sv
// Bench for line_mem_ctrl: table of fill/writeback vectors on a LATENCY=4 instance, plus
// hand sequences for LATENCY=0 timing, back-pressure, reset abort and optional stats.
module tb_line_mem_ctrl;
  localparam int L = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         req_valid, req_ready, req_write, resp_valid, busy;
  logic [31:0]  req_addr;
  logic [127:0] req_wbdata, resp_ldata;
  logic         z_valid, z_ready, z_write, z_resp_valid, z_busy;
  logic [31:0]  z_addr;
  logic [127:0] z_wbdata, z_resp_ldata;
`ifdef LINE_MEM_STATS_EN
  logic [31:0]  fill_cnt, wb_cnt, z_fill_cnt, z_wb_cnt;
`endif

  line_mem_ctrl #(.MEM_WORDS(4096), .LATENCY(L)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wbdata(req_wbdata),
    .resp_valid(resp_valid), .resp_ldata(resp_ldata), .busy(busy)
`ifdef LINE_MEM_STATS_EN
    , .fill_cnt(fill_cnt), .wb_cnt(wb_cnt)
`endif
  );

  line_mem_ctrl #(.MEM_WORDS(4096), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(z_valid), .req_ready(z_ready),
    .req_write(z_write), .req_addr(z_addr), .req_wbdata(z_wbdata),
    .resp_valid(z_resp_valid), .resp_ldata(z_resp_ldata), .busy(z_busy)
`ifdef LINE_MEM_STATS_EN
    , .fill_cnt(z_fill_cnt), .wb_cnt(z_wb_cnt)
`endif
  );

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[7];
  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;
  int resp_cnt = 0;
  int exp_fill = 0;
  int exp_wb = 0;

  localparam logic [127:0] LINE_A  = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] LINE_B  = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] LINE_C  = 128'hCAFEF00D_DEADBEEF_0BADC0DE_12345678;
  localparam logic [127:0] LINE_BP = 128'h0F0F0F0F_F0F0F0F0_A5A5A5A5_5A5A5A5A;
  localparam logic [127:0] LINE_Z  = 128'h13579BDF_2468ACE0_FFFF0000_0000FFFF;
  localparam logic [127:0] LINE_D  = 128'h9999AAAA_BBBBCCCC_DDDDEEEE_FFFF0001;

  // Acceptance and response pulses are observed mid-cycle, where inputs and outputs are stable.
  always @(negedge clk) begin
    if (rst && req_valid && req_ready) acc_cnt <= acc_cnt + 1;
    if (resp_valid) resp_cnt <= resp_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [127:0] wd,
                        input logic [127:0] exp, input string name);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin step(); n++; end
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = addr;
    req_wbdata = wd;
    step();
    req_valid  = 1'b0;
    req_write  = ~wr;
    req_addr   = 32'hDEAD_BEEF;
    req_wbdata = '1;
    n = 0;
    do begin step(); n++; end while (!resp_valid && n < 40);
    check({name, " latency"}, 128'(n), 128'(L + 4));
    check({name, " ldata"}, resp_ldata, exp);
    step();
    check({name, " post valid/ready/hold"}, {resp_valid, req_ready, resp_ldata}, {1'b0, 1'b1, exp});
    if (wr) exp_wb++;
    else    exp_fill++;
  endtask

  initial begin
    int n, k, a0, r0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wbdata = '0;
    z_valid = 1'b0; z_write = 1'b0; z_addr = '0; z_wbdata = '0;

    vecs[0] = '{1'b1, 32'h0000_0040, LINE_A, LINE_A};
    vecs[1] = '{1'b0, 32'h0000_004C, '0,     LINE_A};
    vecs[2] = '{1'b1, 32'h0001_0010, LINE_B, LINE_B};
    vecs[3] = '{1'b0, 32'h0000_0010, '0,     LINE_B};
    vecs[4] = '{1'b1, 32'h0000_3FF0, LINE_C, LINE_C};
    vecs[5] = '{1'b0, 32'h0000_3FFF, '0,     LINE_C};
    vecs[6] = '{1'b0, 32'h0000_0040, '0,     LINE_A};

    // Reset state.
    step(); step();
    check("reset outputs", {req_ready, busy, resp_valid, resp_ldata}, {1'b1, 1'b0, 1'b0, 128'h0});
    check("reset outputs L0", {z_ready, z_busy, z_resp_valid}, 3'b100);
`ifdef LINE_MEM_STATS_EN
    check("reset counters", {fill_cnt, wb_cnt}, 64'h0);
`endif
    rst = 1'b1;
    step();

    for (int i = 0; i < 7; i++) begin
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // LATENCY=0: writeback then fill of the same line, checking cycle-exact handshake.
    for (int pass = 0; pass < 2; pass++) begin
      z_valid  = 1'b1;
      z_write  = (pass == 0);
      z_addr   = 32'h0000_0084;
      z_wbdata = (pass == 0) ? LINE_Z : '0;
      step();
      z_valid  = 1'b0;
      z_wbdata = '1;
      for (int c = 1; c <= 6; c++) begin
        step();
        check($sformatf("l0 pass%0d edge+%0d valid/ready", pass, c),
              {z_resp_valid, z_ready}, {c == 4, c >= 5});
        if (c == 4) check($sformatf("l0 pass%0d ldata", pass), z_resp_ldata, LINE_Z);
      end
    end

    // Back-pressure: a fill held valid while a writeback to the same line is in flight.
    a0 = acc_cnt;
    r0 = resp_cnt;
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_addr   = 32'h0000_0100;
    req_wbdata = LINE_BP;
    step();
    req_write  = 1'b0;
    req_wbdata = '0;
    k = 0;
    do begin @(negedge clk); k++; end while (!req_ready && k < 40);
    check("bp second accept edge", 128'(k), 128'(L + 6));
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    do begin step(); n++; end while (!resp_valid && n < 40);
    check("bp fill latency", 128'(n), 128'(L + 4));
    check("bp fill ldata", resp_ldata, LINE_BP);
    step();
    check("bp accept count", 128'(acc_cnt - a0), 128'd2);
    check("bp resp count", 128'(resp_cnt - r0), 128'd2);
    exp_wb++;
    exp_fill++;

    // Reset during the second writeback, after beats 0 and 1 have committed.
    do_req(1'b1, 32'h0000_0200, {4{32'hAAAA_AAAA}}, {4{32'hAAAA_AAAA}}, "rst wb1");
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_addr   = 32'h0000_0200;
    req_wbdata = {4{32'h5555_5555}};
    step();
    req_valid  = 1'b0;
    r0 = resp_cnt;
    repeat (L + 2) step();
    rst = 1'b0;
    step();
    check("abort outputs", {req_ready, busy, resp_valid, resp_ldata}, {1'b1, 1'b0, 1'b0, 128'h0});
`ifdef LINE_MEM_STATS_EN
    check("abort counters", {fill_cnt, wb_cnt}, 64'h0);
`endif
    exp_fill = 0;
    exp_wb   = 0;
    rst = 1'b1;
    repeat (L + 8) step();
    check("abort no resp", 128'(resp_cnt - r0), 128'd0);
    do_req(1'b0, 32'h0000_0200, '0, 128'hAAAAAAAA_AAAAAAAA_55555555_55555555, "abort fill");
    do_req(1'b1, 32'h0000_0300, LINE_D, LINE_D, "post wb");
    do_req(1'b0, 32'h0000_0308, '0, LINE_D, "post fill");
`ifdef LINE_MEM_STATS_EN
    check("stats fill_cnt", 128'(fill_cnt), 128'(exp_fill));
    check("stats wb_cnt", 128'(wb_cnt), 128'(exp_wb));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
